// File: rtl/regfile_access_sequencer.sv
// regfile_access_sequencer
//   Operand fetch / write-back sequencer sitting directly in front of the
//   file-register RAM block. It resolves direct or INDF/FSR addressing to a
//   9-bit register-file address. It then runs the registered RAM read and
//   hands the captured operand to the ALU. Finally it issues the write-back
//   strobe. The address is held stable for the whole access.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   start               one-cycle access request (accepted in IDLE only)
//   f_addr, rd_req,     decoded file address and read/write intent,
//   wr_req              sampled together with start
//   status_irp/rp,      bank / indirect-pointer state used to form the
//   fsr_val             effective address at start
//   alu_done/result     ALU completion handshake and write-back data
//   regfile_data_out    RAM read data
//   regfile_addr/rd_en/ RAM address, strobes and write data
//   wr_en/data_in
//   operand(_valid)     captured f value and its one-cycle update pulse
//   busy, done          access in progress / one-cycle completion pulse
module regfile_access_sequencer #(
  parameter int         READ_LATENCY = 2,
  parameter logic [6:0] INDF_ADDR    = 7'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] f_addr,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       status_irp,
  input  logic [1:0] status_rp,
  input  logic [7:0] fsr_val,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  input  logic [7:0] regfile_data_out,
  output logic [8:0] regfile_addr,
  output logic       regfile_rd_en,
  output logic       regfile_wr_en,
  output logic [7:0] regfile_data_in,
  output logic [7:0] operand,
  output logic       operand_valid,
  output logic       busy,
  output logic       done
);

  // The WAIT stay is READ_LATENCY-1 cycles, so the counter is loaded with
  // READ_LATENCY-2 and exits on zero.
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, CAPT, EXEC, WRITE, FIN
  } state_t;

  state_t        state_q, state_d;
  logic          wr_req_q, wr_req_d;
  logic          null_q, null_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    addr_q, addr_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    op_q, op_d;
  logic          opv_q, opv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          indirect;

  always_comb begin
    state_d  = state_q;
    wr_req_d = wr_req_q;
    null_d   = null_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    op_d     = op_q;
    opv_d    = 1'b0;
    indirect = (f_addr == INDF_ADDR);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Address and null flag are frozen here; later STATUS/FSR
          // changes must not disturb the access in flight.
          wr_req_d = wr_req;
          addr_d   = indirect ? {status_irp, fsr_val} : {status_rp, f_addr};
          null_d   = indirect && (fsr_val == 8'h00);
          if (rd_req && !(indirect && (fsr_val == 8'h00))) begin
            state_d = READ;
          end else begin
            state_d = EXEC;
            if (rd_req) begin
              // INDF through FSR==0 reads as zero without touching the RAM.
              op_d  = 8'h00;
              opv_d = 1'b1;
            end
          end
        end
      end
      READ: begin
        if (READ_LATENCY == 1) begin
          state_d = CAPT;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = CAPT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CAPT: begin
        op_d    = regfile_data_out;
        opv_d   = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        if (alu_done) begin
          if (wr_req_q && !null_q) begin
            din_d   = alu_result;
            state_d = WRITE;
          end else begin
            state_d = FIN;
          end
        end
      end
      WRITE:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes and status are registered images of the state being entered,
    // so each is high for exactly the cycle spent in that state.
    rd_en_d = (state_d == READ);
    wr_en_d = (state_d == WRITE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_req_q <= 1'b0;
      null_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= 9'h000;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      din_q    <= 8'h00;
      op_q     <= 8'h00;
      opv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_req_q <= wr_req_d;
      null_q   <= null_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      din_q    <= din_d;
      op_q     <= op_d;
      opv_q    <= opv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign regfile_addr    = addr_q;
  assign regfile_rd_en   = rd_en_q;
  assign regfile_wr_en   = wr_en_q;
  assign regfile_data_in = din_q;
  assign operand         = op_q;
  assign operand_valid   = opv_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
module tb_regfile_access_sequencer;
  localparam int         RL   = 2;
  localparam logic [6:0] INDF = 7'h00;

  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 0, rd_req = 0, wr_req = 0, status_irp = 0, alu_done = 0;
  logic [6:0] f_addr = 0;
  logic [1:0] status_rp = 0;
  logic [7:0] fsr_val = 0, alu_result = 0, regfile_data_out;
  logic [8:0] regfile_addr;
  logic       regfile_rd_en, regfile_wr_en, operand_valid, busy, done;
  logic [7:0] regfile_data_in, operand;

  int checks = 0, errors = 0;

  regfile_access_sequencer #(.READ_LATENCY(RL), .INDF_ADDR(INDF)) dut (
    .clk(clk), .rst(rst), .start(start), .f_addr(f_addr), .rd_req(rd_req),
    .wr_req(wr_req), .status_irp(status_irp), .status_rp(status_rp),
    .fsr_val(fsr_val), .alu_done(alu_done), .alu_result(alu_result),
    .regfile_data_out(regfile_data_out), .regfile_addr(regfile_addr),
    .regfile_rd_en(regfile_rd_en), .regfile_wr_en(regfile_wr_en),
    .regfile_data_in(regfile_data_in), .operand(operand),
    .operand_valid(operand_valid), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // RAM block: registered read, data appears RL edges after the rd_en cycle.
  logic [7:0] ram [512];
  logic [7:0] ref_mem [512];
  logic [7:0] dpipe [RL];
  logic       pl_en = 0;
  logic [8:0] pl_addr = 0;
  logic [7:0] pl_data = 0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (regfile_wr_en) ram[regfile_addr] <= regfile_data_in;
    if (regfile_rd_en) dpipe[0] <= ram[regfile_addr];
    for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
  end
  assign regfile_data_out = dpipe[RL-1];

  typedef struct {
    logic [6:0] f; logic [1:0] rp; logic irp; logic [7:0] fsr;
    logic rd, wr; logic [7:0] ram_v, alu; int dly; bit chg, xs;
    logic [8:0] e_addr; logic e_rd, e_wr, e_opv; logic [7:0] e_op;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic [6:0] f, logic [1:0] rp, logic irp, logic [7:0] fsr,
      logic rd, logic wr, logic [7:0] rv, logic [7:0] alu, int dly, bit chg, bit xs,
      logic [8:0] ea, logic erd, logic ewr, logic eopv, logic [7:0] eop);
    vec_t v;
    v.f = f; v.rp = rp; v.irp = irp; v.fsr = fsr; v.rd = rd; v.wr = wr;
    v.ram_v = rv; v.alu = alu; v.dly = dly; v.chg = chg; v.xs = xs;
    v.e_addr = ea; v.e_rd = erd; v.e_wr = ewr; v.e_opv = eopv; v.e_op = eop;
    return v;
  endfunction

  // Reference model: expected behaviour straight from the addressing rules.
  function automatic vec_t model(input vec_t v);
    bit ind, nul;
    ind = (v.f == INDF);
    nul = ind && (v.fsr == 8'h00);
    v.e_addr = ind ? {v.irp, v.fsr} : {v.rp, v.f};
    v.e_rd   = v.rd && !nul;
    v.e_wr   = v.wr && !nul;
    v.e_opv  = v.rd;
    v.e_op   = nul ? 8'h00 : ref_mem[v.e_addr];
    return v;
  endfunction

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk); pl_en = 1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_en = 0;
    ref_mem[a] = d;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc = 0, rdc = 0, wrc = 0, both = 0, opvc = 0, donec = 0, lat = 0;
    int done_cyc = 0, rdy = -1, busy_lo = 0, addr_bad = 0, xbusy = 0, xdone = 0, base;
    logic [7:0] opval = 0, wdata = 0;
    bit fin = 0;
    @(negedge clk);
    f_addr = v.f; status_rp = v.rp; status_irp = v.irp; fsr_val = v.fsr;
    rd_req = v.rd; wr_req = v.wr; alu_result = v.alu; alu_done = 0; start = 1;
    while (!fin && cyc < 200) begin
      @(negedge clk); cyc++;
      if (regfile_rd_en) rdc++;
      if (regfile_wr_en) begin wrc++; wdata = regfile_data_in; end
      if (regfile_rd_en && regfile_wr_en) both++;
      if (regfile_addr !== v.e_addr) addr_bad++;
      if (!busy) busy_lo++;
      if (operand_valid) begin opvc++; opval = operand; lat = cyc; end
      if (done) begin donec++; done_cyc = cyc; fin = 1; end
      start = 0;
      if (v.xs && cyc == 2) begin start = 1; f_addr = 7'h01; rd_req = 1; wr_req = 1; end
      if (v.chg && cyc == 2) begin fsr_val = 8'h40; status_irp = ~v.irp; status_rp = ~v.rp; end
      if (rdy < 0 && (operand_valid || !v.rd)) rdy = cyc;
      if (rdy >= 0 && cyc - rdy >= v.dly && !fin) alu_done = 1;
    end
    alu_done = 0;
    if (!fin) chk($sformatf("v%0d_timeout", id), 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = 0;
      if (busy) xbusy++;
      if (done) xdone++;
    end
    if (v.e_wr) ref_mem[v.e_addr] = v.alu;
    base = v.e_rd ? 2 + RL : 1;
    chk($sformatf("v%0d_addr_stable", id), addr_bad, 0);
    chk($sformatf("v%0d_rd_cnt", id), rdc, 32'(v.e_rd));
    chk($sformatf("v%0d_wr_cnt", id), wrc, 32'(v.e_wr));
    chk($sformatf("v%0d_rd_wr_overlap", id), both, 0);
    chk($sformatf("v%0d_opv_cnt", id), opvc, 32'(v.e_opv));
    if (v.e_opv) begin
      chk($sformatf("v%0d_operand", id), opval, v.e_op);
      chk($sformatf("v%0d_op_latency", id), lat, base);
    end
    if (v.e_wr) begin
      chk($sformatf("v%0d_wr_data", id), wdata, v.alu);
      chk($sformatf("v%0d_din_hold", id), regfile_data_in, v.alu);
    end
    chk($sformatf("v%0d_done_cnt", id), donec + xdone, 1);
    chk($sformatf("v%0d_done_cycle", id), done_cyc, base + v.dly + (v.e_wr ? 2 : 1));
    chk($sformatf("v%0d_busy_low", id), busy_lo, 0);
    chk($sformatf("v%0d_idle_after", id), xbusy, 0);
    chk($sformatf("v%0d_ram", id), ram[v.e_addr], ref_mem[v.e_addr]);
  endtask

  vec_t tbl [8];

  initial begin
    vec_t v;
    int n;
    bit seen;
    tbl[0] = mkv(7'h20, 2'b01, 0, 8'h55, 1, 1, 8'h5A, 8'h5B, 0, 0, 0, 9'h0A0, 1, 1, 1, 8'h5A);
    tbl[1] = mkv(7'h00, 2'b00, 1, 8'h30, 1, 0, 8'hC3, 8'h11, 1, 1, 0, 9'h130, 1, 0, 1, 8'hC3);
    tbl[2] = mkv(7'h00, 2'b10, 0, 8'h00, 1, 1, 8'h77, 8'h99, 2, 0, 0, 9'h000, 0, 0, 1, 8'h00);
    tbl[3] = mkv(7'h70, 2'b11, 0, 8'h12, 0, 1, 8'h3C, 8'hA5, 0, 0, 1, 9'h1F0, 0, 1, 0, 8'h00);
    tbl[4] = mkv(7'h15, 2'b10, 1, 8'hFF, 0, 0, 8'h44, 8'h66, 3, 0, 0, 9'h115, 0, 0, 0, 8'h00);
    tbl[5] = mkv(7'h7F, 2'b00, 0, 8'h00, 1, 0, 8'hE1, 8'h00, 10, 0, 0, 9'h07F, 1, 0, 1, 8'hE1);
    tbl[6] = mkv(7'h00, 2'b01, 1, 8'h00, 0, 1, 8'h08, 8'h2D, 0, 0, 0, 9'h100, 0, 0, 0, 8'h00);
    tbl[7] = mkv(7'h2A, 2'b00, 0, 8'h00, 1, 1, 8'hF0, 8'h0F, 10, 0, 0, 9'h02A, 1, 1, 1, 8'hF0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {regfile_addr, regfile_rd_en, regfile_wr_en, regfile_data_in,
                          operand, operand_valid, busy, done}, 0);

    // Fill the RAM (reset still applied) so the model and RAM agree.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk); pl_en = 1; pl_addr = 9'(i); pl_data = 8'($urandom);
      ref_mem[i] = pl_data;
    end
    @(negedge clk); pl_en = 0; rst = 0;
    @(negedge clk);
    chk("post_reset_idle", {busy, done, regfile_rd_en, regfile_wr_en}, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      preload(tbl[i].e_addr, tbl[i].ram_v);
      run_vec(tbl[i], i);
    end

    // Randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      v.f   = ($urandom_range(3) == 0) ? INDF : 7'($urandom);
      v.rp  = 2'($urandom); v.irp = 1'($urandom);
      v.fsr = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      v.rd  = 1'($urandom); v.wr = 1'($urandom);
      v.ram_v = 0; v.alu = 8'($urandom); v.dly = $urandom_range(3);
      v.chg = 1'($urandom); v.xs = 1'($urandom);
      run_vec(model(v), 100 + i);
    end

    // Reset during the write strobe: strobe drops at once, write lost, no done.
    @(negedge clk);
    f_addr = 7'h33; status_rp = 2'b00; rd_req = 0; wr_req = 1; alu_result = 8'hEE; start = 1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); start = 0; alu_done = 1;
      if (regfile_wr_en) seen = 1;
    end
    if (!seen) chk("rstwr_timeout", 0, 1);
    rst = 1; #1;
    chk("rstwr_async_clear", {regfile_wr_en, busy, regfile_addr}, 0);
    alu_done = 0; n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("rstwr_no_done", n, 0);
    chk("rstwr_ram_untouched", ram[9'h033], ref_mem[9'h033]);
    chk("rstwr_din_cleared", regfile_data_in, 0);
    rst = 0;
    v = mkv(7'h20, 2'b01, 0, 8'h00, 1, 1, 0, 8'h3D, 1, 0, 0, 0, 0, 0, 0, 0);
    run_vec(model(v), 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/regfile_access_sequencer.md
Name: regfile_access_sequencer

Overview:
- Operand fetch/write-back sequencer placed directly upstream of the file-register RAM block.
- Takes a decoded 7-bit file address from the instruction decoder and resolves direct or indirect (INDF/FSR) addressing to the 9-bit register-file address.
- Sequences the multi-cycle registered read, hands the operand to the ALU, then performs the write-back strobe.
- Holds the address stable for the whole access, as the RAM block requires.

Parameters:
- READ_LATENCY, 2: clock edges from the end of the rd_en cycle until regfile_data_out is valid. Legal range ≥1.
- INDF_ADDR, 7'h00: file address that selects indirect access.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle instruction-access request; sampled only in IDLE
- f_addr  in  7  decoded file address (instruction bits 6:0)
- rd_req  in  1  instruction reads f (sampled with start)
- wr_req  in  1  instruction writes result to f (sampled with start)
- status_irp  in  1  STATUS.IRP
- status_rp  in  2  STATUS.RP1:RP0
- fsr_val  in  8  FSR contents
- alu_done  in  1  ALU result valid on alu_result
- alu_result  in  8  value to write back
- regfile_data_out  in  8  RAM block read data ("f")
- regfile_addr  out  9  effective address to the RAM block
- regfile_rd_en  out  1  read strobe
- regfile_wr_en  out  1  write strobe
- regfile_data_in  out  8  write data
- operand  out  8  captured f value for the ALU
- operand_valid  out  1  one-cycle pulse when operand is updated
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the access completes

Behaviour:
- States: IDLE, READ, WAIT, CAPT, EXEC, WRITE, FIN.
- All outputs are registered. On reset (asynchronous, any state): state=IDLE; every output is 0, including regfile_addr=9'h000 and operand=8'h00; the wait counter is cleared.
- IDLE, start=1:
  - Latch rd_req and wr_req.
  - Effective address: if f_addr==INDF_ADDR, regfile_addr={status_irp, fsr_val}; otherwise regfile_addr={status_rp, f_addr}.
  - null flag = indirect AND fsr_val==8'h00.
  - Next state: READ if rd_req and not null; else EXEC. If rd_req and null, load operand=8'h00 and pulse operand_valid.
  - start while busy is ignored and does not queue.
- regfile_addr holds from the cycle after start through FIN. STATUS and FSR changes during an access do not affect it.
- READ: regfile_rd_en=1 for exactly one cycle. Next state is WAIT, or CAPT directly when READ_LATENCY==1.
- WAIT: rd_en=0. Stay READ_LATENCY-1 cycles, counted by a down-counter, then go to CAPT.
- CAPT: operand<=regfile_data_out on the exiting edge. operand_valid=1 during the following (EXEC-first) cycle only. Next state EXEC.
- Read latency for READ_LATENCY=2: start edge E0; rd_en high E1–E2; operand valid after E4. Total 4 edges from start to operand_valid.
- EXEC: wait indefinitely for alu_done.
  - alu_done=1 and wr_req and not null: regfile_data_in<=alu_result, go to WRITE.
  - Otherwise go to FIN.
  - alu_done in the same cycle as operand_valid is accepted.
- WRITE: regfile_wr_en=1 for exactly one cycle, with addr and data stable. Next state FIN.
- Null write (INDF with FSR==0): wr_en never asserts; the access still completes normally.
- FIN: done=1 for one cycle, busy=0 on the next edge, next state IDLE.
  - A start in the FIN cycle is ignored; start is accepted from IDLE only.
  - Back-to-back accesses are therefore spaced by at least one IDLE cycle.
- rd_req=0, wr_req=0: the path is IDLE→EXEC→FIN. No strobes assert; completion still waits for alu_done.
- rd_en and wr_en are never high in the same cycle. Each asserts at most once per access.
- regfile_data_in holds its value between accesses and is cleared only by reset.
- Reset asserted mid-READ/WAIT/WRITE: strobes drop immediately (asynchronously). No done pulse. A pending write is lost.

Test Plan:
- Direct read-modify-write (status_rp=2'b01, f_addr=7'h20, RAM 0x0A0 holds 8'h5A, alu_result=8'h5B on alu_done): regfile_addr=9'h0A0; rd_en one cycle; operand=8'h5A with operand_valid 4 edges after start; wr_en one cycle with data_in=8'h5B; done pulse; 0x0A0 reads back 8'h5B.
- Indirect read (f_addr=7'h00, status_irp=1, fsr_val=8'h30, RAM 0x130=8'hC3): regfile_addr=9'h130; operand=8'hC3. Changing FSR to 8'h40 mid-access leaves addr at 9'h130.
- Null indirect (f_addr=7'h00, fsr_val=8'h00, rd_req=1, wr_req=1): no rd_en and no wr_en; operand=8'h00 pulsed; done after alu_done.
- Write-only (rd_req=0, wr_req=1, f_addr=7'h70, rp=2'b11): addr=9'h1F0; no rd_en; wr_en one cycle after alu_done; a start asserted while busy is ignored; exactly one done pulse.
- ALU stall: hold alu_done=0 for 10 cycles in EXEC; busy stays 1, no strobes; completion follows alu_done.
- Reset mid-WRITE: assert rst during the wr_en cycle; wr_en, busy and addr go to 0 immediately; no done pulse; after release, a new start proceeds normally.
